// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular FIFO of (pc, instr)
// pairs with first-word fall-through output and a synchronous full flush.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      instr_i,
    input  logic             fetch_valid_i,
    output logic             fetch_ready_o,
    input  logic             flush_i,
    input  logic             dec_ready_i,
    output logic             dec_valid_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      instr_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    // Ready/valid come from registered occupancy only, so a pop never
    // opens a same-cycle push slot when full.
    assign fetch_ready_o = (count != FULL_CNT);
    assign dec_valid_o   = (count != '0);
    assign count_o       = count;

    assign push = fetch_valid_i && fetch_ready_o && !flush_i;
    assign pop  = dec_valid_o && dec_ready_i && !flush_i;

    assign pc_o    = dec_valid_o ? pc_mem[rd_ptr]    : 32'h0;
    assign instr_o = dec_valid_o ? instr_mem[rd_ptr] : 32'h0;

    // Storage is deliberately left out of reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc_i;
            instr_mem[wr_ptr] <= instr_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue model predicts head, count and
// handshake outputs every cycle, including full, empty, flush and async reset.
module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic             clk;
    logic             reset;
    logic [31:0]      pc_i;
    logic [31:0]      instr_i;
    logic             fetch_valid_i;
    logic             fetch_ready_o;
    logic             flush_i;
    logic             dec_ready_i;
    logic             dec_valid_o;
    logic [31:0]      pc_o;
    logic [31:0]      instr_o;
    logic [PTR_W:0]   count_o;

    entry_t sb_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    logic [31:0] prev_pc;

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_i          (pc_i),
        .instr_i       (instr_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .flush_i       (flush_i),
        .dec_ready_i   (dec_ready_i),
        .dec_valid_o   (dec_valid_o),
        .pc_o          (pc_o),
        .instr_o       (instr_o),
        .count_o       (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model, apply one clock edge, then update the model.
    task automatic cycle(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic dr, input logic fl);
        logic do_push;
        logic do_pop;
        fetch_valid_i = fv;
        pc_i          = fv ? pc  : $urandom;
        instr_i       = fv ? ins : $urandom;
        dec_ready_i   = dr;
        flush_i       = fl;
        #1;
        chk("count", 32'(count_o), 32'(sb_q.size()));
        chk("dec_valid", 32'(dec_valid_o), 32'(sb_q.size() != 0));
        chk("fetch_ready", 32'(fetch_ready_o), 32'(sb_q.size() != DEPTH));
        if (sb_q.size() != 0) begin
            chk("head_pc", pc_o, sb_q[0].pc);
            chk("head_instr", instr_o, sb_q[0].instr);
        end else begin
            chk("empty_pc", pc_o, 32'h0);
            chk("empty_instr", instr_o, 32'h0);
        end
        do_push = fv && (sb_q.size() != DEPTH);
        do_pop  = dr && (sb_q.size() != 0);
        @(posedge clk);
        #1;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (do_pop)  void'(sb_q.pop_front());
            if (do_push) sb_q.push_back('{pc: pc, instr: ins});
        end
        fetch_valid_i = 1'b0;
        dec_ready_i   = 1'b0;
        flush_i       = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        fetch_valid_i = 1'b0;
        dec_ready_i   = 1'b0;
        flush_i       = 1'b0;
        pc_i          = '0;
        instr_i       = '0;

        // 1: outputs idle in reset, single push visible after one edge
        #3;
        chk("rst_count", 32'(count_o), 32'h0);
        chk("rst_valid", 32'(dec_valid_o), 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_ready", 32'(fetch_ready_o), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 32'h0, 32'h0000_0013, 1'b0, 1'b0);
        chk("t1_valid", 32'(dec_valid_o), 32'h1);
        chk("t1_pc", pc_o, 32'h0);
        chk("t1_instr", instr_o, 32'h0000_0013);
        chk("t1_count", 32'(count_o), 32'h1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 2: fill to full, ninth push ignored, drain in order
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        chk("t2_full_count", 32'(count_o), 32'd8);
        chk("t2_full_ready", 32'(fetch_ready_o), 32'h0);
        cycle(1'b1, 32'h20, 32'hDEAD_0020, 1'b0, 1'b0);
        chk("t2_ovf_count", 32'(count_o), 32'd8);
        // pop while full with a push offered: push must still be refused
        cycle(1'b1, 32'h24, 32'hDEAD_0024, 1'b1, 1'b0);
        chk("t2_popfull_count", 32'(count_o), 32'd7);
        while (sb_q.size() != 0)
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 3: steady push+pop at count 3 across the pointer wrap
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h300 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
        prev_pc = pc_o - 32'd4;
        for (int i = 3; i < 13; i++) begin
            chk("t3_incr", pc_o, prev_pc + 32'd4);
            prev_pc = pc_o;
            cycle(1'b1, 32'h300 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
            chk("t3_count", 32'(count_o), 32'd3);
        end

        // 4: flush with simultaneous push and pop at count 5
        cycle(1'b1, 32'h340, 32'hB000_0040, 1'b0, 1'b0);
        cycle(1'b1, 32'h344, 32'hB000_0044, 1'b0, 1'b0);
        chk("t4_pre_count", 32'(count_o), 32'd5);
        cycle(1'b1, 32'h100, 32'hC000_0100, 1'b1, 1'b1);
        chk("t4_count", 32'(count_o), 32'h0);
        chk("t4_valid", 32'(dec_valid_o), 32'h0);
        chk("t4_pc", pc_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            chk("t4_no_100", 32'(pc_o == 32'h100), 32'h0);
        end

        // 5: asynchronous reset mid-stream at count 4
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h180 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
        chk("t5_pre_count", 32'(count_o), 32'd4);
        fetch_valid_i = 1'b1;
        dec_ready_i   = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("t5_async_count", 32'(count_o), 32'h0);
        chk("t5_async_valid", 32'(dec_valid_o), 32'h0);
        chk("t5_async_pc", pc_o, 32'h0);
        sb_q.delete();
        fetch_valid_i = 1'b0;
        dec_ready_i   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 32'h200, 32'hE000_0200, 1'b0, 1'b0);
        chk("t5_head_pc", pc_o, 32'h200);
        chk("t5_head_instr", instr_o, 32'hE000_0200);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 6: pops ignored while empty, then a push is delivered next edge
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            chk("t6_count", 32'(count_o), 32'h0);
            chk("t6_valid", 32'(dec_valid_o), 32'h0);
        end
        cycle(1'b1, 32'h40, 32'hF000_0040, 1'b1, 1'b0);
        chk("t6_valid_after", 32'(dec_valid_o), 32'h1);
        chk("t6_pc", pc_o, 32'h40);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
